// File: rtl/diff_sinal_gen_if.sv
// Bundle between the board switches/buttons and diff_sinal_gen, plus the
// status lines read by the 7-segment display and the FSM debug tap.
interface diff_sinal_gen_if;
  logic       btn_target;
  logic       btn_guess;
  logic [3:0] value;
  // There is no back-pressure: valid=1 means diff/sinal hold the result of the
  // most recent accepted guess, and they stay put until the next accepted
  // guess or target load. The display samples them whenever it likes.
  logic [3:0] diff;
  logic       sinal;
  logic       valid;
  logic       match;
  logic [3:0] attempts;
  logic       locked;
  logic [2:0] state_dbg;

  modport master (
    output btn_target, btn_guess, value,
    input  diff, sinal, valid, match, attempts, locked, state_dbg
  );

  modport slave (
    input  btn_target, btn_guess, value,
    output diff, sinal, valid, match, attempts, locked, state_dbg
  );
endinterface

// File: rtl/diff_sinal_gen.sv
// Guess-the-number core: loads a target, scores guesses as |guess-target| and sign.
// Optional attempt lockout is compiled in with `define DIFF_SINAL_LOCK_EN.
module diff_sinal_gen #(
    parameter int MAX_ATTEMPTS = 7
) (
    input logic             clk,
    input logic             reset,
    diff_sinal_gen_if.slave bus
);

    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15) begin : g_bad_max_attempts
        $error("diff_sinal_gen: MAX_ATTEMPTS must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        RESULT = 3'd2,
        WIN    = 3'd3
`ifdef DIFF_SINAL_LOCK_EN
        ,
        LOCK   = 3'd4
`endif
    } state_t;

`ifdef DIFF_SINAL_LOCK_EN
    localparam logic [3:0] ATT_LIMIT = 4'(MAX_ATTEMPTS);
`endif

    // [0] and [1] are the synchronizer, [2] is the edge-detect delay flop.
    logic [2:0] tgt_sync;
    logic [2:0] gss_sync;
    logic       tgt_ev;
    logic       gss_ev;

    state_t     state_q, state_d;
    logic [3:0] target_q, target_d;
    logic [3:0] diff_q, diff_d;
    logic       sinal_q, sinal_d;
    logic       valid_q, valid_d;
    logic       match_q, match_d;
    logic [3:0] attempts_q, attempts_d;
    logic       locked_q, locked_d;
    logic [3:0] attempts_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_sync <= '0;
            gss_sync <= '0;
            tgt_ev   <= 1'b0;
            gss_ev   <= 1'b0;
        end else begin
            tgt_sync <= {tgt_sync[1:0], bus.btn_target};
            gss_sync <= {gss_sync[1:0], bus.btn_guess};
            tgt_ev   <= tgt_sync[1] & ~tgt_sync[2];
            gss_ev   <= gss_sync[1] & ~gss_sync[2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            diff_q     <= '0;
            sinal_q    <= 1'b0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            attempts_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            diff_q     <= diff_d;
            sinal_q    <= sinal_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            attempts_q <= attempts_d;
            locked_q   <= locked_d;
        end
    end

`ifdef DIFF_SINAL_LOCK_EN
    // attempts stays below ATT_LIMIT outside LOCK, so the increment cannot wrap.
    assign attempts_inc = attempts_q + 4'd1;
`else
    assign attempts_inc = (attempts_q == 4'hF) ? 4'hF : attempts_q + 4'd1;
`endif

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        diff_d     = diff_q;
        sinal_d    = sinal_q;
        valid_d    = valid_q;
        match_d    = match_q;
        attempts_d = attempts_q;
        locked_d   = locked_q;

        if (tgt_ev) begin
            // A target load wins over a guess arriving in the same cycle.
            state_d    = ARMED;
            target_d   = bus.value;
            diff_d     = '0;
            sinal_d    = 1'b0;
            valid_d    = 1'b0;
            match_d    = 1'b0;
            attempts_d = '0;
            locked_d   = 1'b0;
        end else if (gss_ev && (state_q == ARMED || state_q == RESULT)) begin
            valid_d = 1'b1;
            if (bus.value == target_q) begin
                state_d = WIN;
                diff_d  = '0;
                sinal_d = 1'b0;
                match_d = 1'b1;
            end else begin
                state_d    = RESULT;
                match_d    = 1'b0;
                sinal_d    = (bus.value < target_q);
                diff_d     = (bus.value < target_q)
                           ? 4'({1'b0, target_q} - {1'b0, bus.value})
                           : 4'({1'b0, bus.value} - {1'b0, target_q});
                attempts_d = attempts_inc;
`ifdef DIFF_SINAL_LOCK_EN
                if (attempts_inc == ATT_LIMIT) begin
                    state_d  = LOCK;
                    locked_d = 1'b1;
                end
`endif
            end
        end else if (!(state_q inside {IDLE, ARMED, RESULT, WIN
`ifdef DIFF_SINAL_LOCK_EN
                                      , LOCK
`endif
                                      })) begin
            state_d = IDLE;
        end
    end

    assign bus.diff      = diff_q;
    assign bus.sinal     = sinal_q;
    assign bus.valid     = valid_q;
    assign bus.match     = match_q;
    assign bus.attempts  = attempts_q;
    assign bus.locked    = locked_q;
    assign bus.state_dbg = state_q;

endmodule
